// File: rtl/spi_reg_pkg.sv
// Shared constants and FSM state type for the SPI PWM register bank.
package spi_reg_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned NUM_REGS   = 5;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'd0;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'd1;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'd2;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'd3;
    localparam logic [6:0] ADDR_DUTY      = 7'd4;

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Pad synchronizer followed by a history flop for single-cycle rise/fall detection.
module sync_edge_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   hist_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= '0;
            hist_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], d};
            hist_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign q    = sync_r[SYNC_STAGES-1];
    assign rise = q & ~hist_r;
    assign fall = ~q & hist_r;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 slave owning the PWM configuration registers.
// Optional SPI_READBACK_EN adds a cipo output that returns register contents on read frames.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [6:0]  MAX_ADDR    = 7'd4
) (
`ifdef SPI_READBACK_EN
    output logic       cipo,
`endif
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe,
    output logic [6:0] wr_addr,
    output logic       frame_err
);

    logic sclk_rise, sclk_fall, unused_sclk_q;
    logic copi_q, unused_copi_rise, unused_copi_fall;
    logic ncs_q, ncs_rise, ncs_fall;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk (clk), .rst (rst), .d (sclk),
        .q (unused_sclk_q), .rise (sclk_rise), .fall (sclk_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
        .clk (clk), .rst (rst), .d (copi),
        .q (copi_q), .rise (unused_copi_rise), .fall (unused_copi_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
        .clk (clk), .rst (rst), .d (ncs),
        .q (ncs_q), .rise (ncs_rise), .fall (ncs_fall)
    );

    state_t      state, state_next;
    logic [4:0]  bit_cnt;
    logic [15:0] shift_reg;
    logic        start, do_shift, do_commit, do_err;
    logic        frame_full, frame_ok, frame_read;

    assign frame_full = (bit_cnt == 5'(FRAME_BITS));
    assign frame_ok   = frame_full && shift_reg[15] && (shift_reg[14:8] <= MAX_ADDR);
    assign frame_read = frame_full && !shift_reg[15];

    always_ff @(posedge clk) begin
        if (rst) state <= WAIT_IDLE;
        else     state <= state_next;
    end

    // The write is decided on the ncs-rise cycle itself; COMMIT is only a dwell
    // cycle that keeps a fresh ncs fall from being seen right after a frame.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        do_shift   = 1'b0;
        do_commit  = 1'b0;
        do_err     = 1'b0;
        case (state)
            WAIT_IDLE: if (ncs_q) state_next = IDLE;
            IDLE: begin
                if (ncs_fall) begin
                    state_next = SHIFT;
                    start      = 1'b1;
                end
            end
            SHIFT: begin
                if (ncs_rise) begin
                    state_next = COMMIT;
                    do_commit  = frame_ok;
                    do_err     = !frame_ok && !frame_read;
                end else if (sclk_rise) begin
                    do_shift = 1'b1;
                end
            end
            COMMIT:  state_next = IDLE;
            default: state_next = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt         <= '0;
            shift_reg       <= '0;
            en_reg_out_7_0  <= '0;
            en_reg_out_15_8 <= '0;
            en_reg_pwm_7_0  <= '0;
            en_reg_pwm_15_8 <= '0;
            pwm_duty_cycle  <= '0;
            wr_addr         <= '0;
            wr_strobe       <= 1'b0;
            frame_err       <= 1'b0;
        end else begin
            wr_strobe <= do_commit;
            frame_err <= do_err;
            if (start) begin
                bit_cnt   <= '0;
                shift_reg <= '0;
            end else if (do_shift) begin
                shift_reg <= {shift_reg[14:0], copi_q};
                if (bit_cnt != 5'(FRAME_BITS + 1)) bit_cnt <= bit_cnt + 5'd1;
            end
            if (do_commit) begin
                wr_addr <= shift_reg[14:8];
                case (shift_reg[14:8])
                    ADDR_EN_OUT_LO: en_reg_out_7_0  <= shift_reg[7:0];
                    ADDR_EN_OUT_HI: en_reg_out_15_8 <= shift_reg[7:0];
                    ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= shift_reg[7:0];
                    ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= shift_reg[7:0];
                    ADDR_DUTY:      pwm_duty_cycle  <= shift_reg[7:0];
                    default: ;
                endcase
            end
        end
    end

`ifdef SPI_READBACK_EN
    logic       rd_ok;
    logic [6:0] rd_addr;
    logic [7:0] rd_byte;
    logic [15:0] hdr_next;

    assign hdr_next = {shift_reg[14:0], copi_q};

    always_comb begin
        rd_byte = '0;
        case (rd_addr)
            ADDR_EN_OUT_LO: rd_byte = en_reg_out_7_0;
            ADDR_EN_OUT_HI: rd_byte = en_reg_out_15_8;
            ADDR_EN_PWM_LO: rd_byte = en_reg_pwm_7_0;
            ADDR_EN_PWM_HI: rd_byte = en_reg_pwm_15_8;
            ADDR_DUTY:      rd_byte = pwm_duty_cycle;
            default:        rd_byte = '0;
        endcase
    end

    // Header is latched on the 8th shift so cipo can start on the following SCLK fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ok   <= 1'b0;
            rd_addr <= '0;
            cipo    <= 1'b0;
        end else begin
            if (start) begin
                rd_ok <= 1'b0;
            end else if (do_shift && bit_cnt == 5'd7) begin
                rd_ok   <= !hdr_next[7] && (hdr_next[6:0] <= MAX_ADDR)
                           && (hdr_next[6:0] < 7'(NUM_REGS));
                rd_addr <= hdr_next[6:0];
            end
            if (state != SHIFT) begin
                cipo <= 1'b0;
            end else if (sclk_fall) begin
                if (rd_ok && bit_cnt >= 5'd8 && bit_cnt <= 5'd15)
                    cipo <= rd_byte[3'(5'd15 - bit_cnt)];
                else
                    cipo <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// Randomized bench for spi_reg_bank against a frame-level register model.
// Build with SPI_READBACK_EN defined to also check cipo data.
module tb_spi_reg_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       copi = 1'b0;
    logic       ncs = 1'b1;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       wr_strobe, frame_err;
    logic [6:0] wr_addr;
`ifdef SPI_READBACK_EN
    logic       cipo;
`endif

    spi_reg_bank #(.SYNC_STAGES(2), .MAX_ADDR(7'd4)) dut (
`ifdef SPI_READBACK_EN
        .cipo            (cipo),
`endif
        .clk             (clk),
        .rst             (rst),
        .sclk            (sclk),
        .copi            (copi),
        .ncs             (ncs),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .wr_strobe       (wr_strobe),
        .wr_addr         (wr_addr),
        .frame_err       (frame_err)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [7:0]  m_regs [5];
    logic [6:0]  m_wr_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".out_lo"}, 32'(en_reg_out_7_0),  32'(m_regs[0]));
        check({tag, ".out_hi"}, 32'(en_reg_out_15_8), 32'(m_regs[1]));
        check({tag, ".pwm_lo"}, 32'(en_reg_pwm_7_0),  32'(m_regs[2]));
        check({tag, ".pwm_hi"}, 32'(en_reg_pwm_15_8), 32'(m_regs[3]));
        check({tag, ".duty"},   32'(pwm_duty_cycle),  32'(m_regs[4]));
        check({tag, ".wr_addr"}, 32'(wr_addr),        32'(m_wr_addr));
    endtask

    // Sends the low n bits of v MSB first; rst_at >= 0 pulses rst before that bit.
    task automatic send_frame(input string tag, input logic [16:0] v, input int n, input int rst_at);
        int   strobes = 0;
        int   errs = 0;
        int   first = -1;
        bit   was_reset = 0;
        bit   hit, rd, err;
        logic [6:0] addr;
        logic [7:0] hdr;
        hdr  = (n >= 8) ? v[n-1 -: 8] : 8'h00;
        ncs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                was_reset = 1;
                foreach (m_regs[k]) m_regs[k] = 8'h00;
                m_wr_addr = 7'd0;
            end
            copi = v[n-1-i];
            repeat (4) @(negedge clk);
`ifdef SPI_READBACK_EN
            if (!was_reset && i >= 8 && i <= 15) begin
                if (!hdr[7] && hdr[6:0] <= 7'd4)
                    check({tag, ".cipo"}, 32'(cipo), 32'(m_regs[hdr[2:0]][15-i]));
                else
                    check({tag, ".cipo0"}, 32'(cipo), 32'd0);
            end
`endif
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        ncs = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (wr_strobe) begin
                strobes++;
                if (first < 0) first = c;
            end
            if (frame_err) errs++;
        end
        addr = v[14:8];
        hit  = !was_reset && n == 16 && v[15] && addr <= 7'd4;
        rd   = n == 16 && !v[15];
        err  = !was_reset && !hit && !rd;
        check({tag, ".strobes"}, 32'(strobes), 32'(hit));
        check({tag, ".errs"},    32'(errs),    32'(err));
        if (hit) begin
            check({tag, ".latency_ok"}, 32'(first >= 1 && first <= 4), 32'd1);
            m_regs[addr[2:0]] = v[7:0];
            m_wr_addr = addr;
        end
        check_regs(tag);
    endtask

    initial begin
        int n;
        logic [16:0] v;
        int strobes;
        foreach (m_regs[k]) m_regs[k] = 8'h00;
        m_wr_addr = 7'd0;

        repeat (3) @(negedge clk);
        check("reset.strobe", 32'(wr_strobe), 32'd0);
        check("reset.err",    32'(frame_err), 32'd0);
        check_regs("reset");
        rst = 1'b0;
        repeat (6) @(negedge clk);

        send_frame("t1_write_a5",    17'h080A5, 16, -1);
        send_frame("t2_duty",        17'h08480, 16, -1);
        send_frame("t3_short15",     17'h00A5A, 15, -1);
        send_frame("t3_long17",      17'h18111, 17, -1);
        send_frame("t4_bad_addr",    17'h08533, 16, -1);
        send_frame("t4_read",        17'h000FF, 16, -1);
        send_frame("t5_rst_mid",     17'h08142, 16, 9);
        repeat (4) @(negedge clk);
        send_frame("t5_after",       17'h08142, 16, -1);
        send_frame("t6_write_3c",    17'h0833C, 16, -1);
        send_frame("t6_read_3",      17'h00300, 16, -1);

        // SCLK activity with nCS high must be ignored.
        strobes = 0;
        for (int i = 0; i < 3; i++) begin
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            if (wr_strobe || frame_err) strobes++;
            sclk = 1'b0;
            repeat (4) @(negedge clk);
            if (wr_strobe || frame_err) strobes++;
        end
        check("idle_sclk.pulses", 32'(strobes), 32'd0);
        check_regs("idle_sclk");

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 9))
                0:       n = 15;
                1:       n = 17;
                2:       n = 8;
                default: n = 16;
            endcase
            v = 17'($urandom);
            if (n == 16) begin
                v[15]   = ($urandom_range(0, 3) != 0);
                v[14:8] = 7'($urandom_range(0, 6));
            end
            send_frame($sformatf("rnd%0d", t), v, n, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
